host_packet_buffer: RTL
=======================

Name: host_packet_buffer

Overview:
- Upstream stage of the controller.
- Accepts a host byte stream (valid/ready) and assembles fixed-size packets of {address, data}, little-endian.
- Queues complete packets in a first-word-fall-through FIFO.
- Presents the FIFO head to the controller as buffer_addr/buffer_data with buffer_empty. The controller pops with buffer_read_enable.

Parameters:
- BUFFER_LENGTH, 16, address field width; bit layout is decoded downstream.
- DATA_WIDTH, 32, data field width; must be a multiple of 8.
- FIFO_DEPTH, 16, packets held; must be a power of two and at least 2.
- TIMEOUT_CYCLES, 1024, idle cycles before a partial packet is discarded; used only with the optional feature.

Ports:
- clk  in  1  clock.
- reset  in  1  reset: asynchronous, active-high.
- in_data  in  8  host byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  byte is accepted at the edge when in_valid&in_ready.
- buffer_empty  out  1  FIFO holds no packet.
- buffer_addr  out  BUFFER_LENGTH  head packet address.
- buffer_data  out  DATA_WIDTH  head packet data.
- buffer_read_enable  in  1  pop head at the edge.
- buffer_count  out  $clog2(FIFO_DEPTH)+1  packets stored.
- timeout_pulse  out  1  one-cycle pulse when a partial packet is discarded.

Behaviour:
- Derived constants:
  - ADDR_BYTES = ceil(BUFFER_LENGTH/8).
  - DATA_BYTES = DATA_WIDTH/8.
  - PKT_BYTES = ADDR_BYTES+DATA_BYTES.
- Reset values:
  - byte_cnt=0, wr_ptr=rd_ptr=0, buffer_count=0.
  - buffer_empty=1, in_ready=1, timeout_pulse=0.
  - Packet shift register is cleared; FIFO storage is not reset.
  - Reset mid-packet or mid-FIFO discards everything.
- Assembler state is byte_cnt, range 0..PKT_BYTES-1.
  - Each accepted byte is written to byte lane byte_cnt of the packet register.
  - Lanes 0..ADDR_BYTES-1 form the address, LSB first; address bits above BUFFER_LENGTH are dropped.
  - The remaining lanes form the data, LSB first.
- On acceptance of the byte at byte_cnt=PKT_BYTES-1, the final byte is merged into the packet combinationally and the packet is pushed into the FIFO at the same edge. byte_cnt then returns to 0. Otherwise byte_cnt increments.
- in_ready = (byte_cnt != PKT_BYTES-1) | ~full, where full = (buffer_count == FIFO_DEPTH) and is registered state.
  - in_ready does not depend on buffer_read_enable, so there is no combinational path host->controller.
  - Consequence: a push is never attempted while full.
- The FIFO is first-word-fall-through:
  - buffer_addr/buffer_data reflect mem[rd_ptr] whenever buffer_empty=0.
  - Their value while empty is don't-care.
- Latency: last byte accepted at edge N -> buffer_empty=0 and head valid after edge N (visible in cycle N+1) when the FIFO was empty.
- Pop: buffer_read_enable & ~buffer_empty advances rd_ptr at the edge. buffer_read_enable while empty is ignored; pointers and count are unchanged.
- Simultaneous push and pop: buffer_count is unchanged and both pointers advance.
  - With buffer_count=1, the popped head is replaced by the new packet in the next cycle; buffer_empty stays 0.
- Pointers are $clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
- buffer_empty = (buffer_count==0) is a registered compare.
- Packet order is strictly preserved; no packet is dropped or duplicated.

Optional Feature:
- Macro: HOST_PACKET_BUFFER_TIMEOUT_EN.
- Enabled:
  - An idle counter clears on every accepted byte and while byte_cnt==0.
  - It increments each cycle while byte_cnt!=0 and no byte is accepted.
  - When it reaches TIMEOUT_CYCLES-1: byte_cnt<=0, the partial packet is discarded, timeout_pulse=1 for exactly one cycle, and the counter clears.
  - A byte accepted in the same cycle as expiry takes precedence: no timeout, and the byte is processed normally.
- Disabled: no counter logic, timeout_pulse is tied 0, and a partial packet waits indefinitely.

Test Plan:
1. Single packet, defaults: bytes 34 12 EF BE AD DE with in_valid continuous -> buffer_empty falls the cycle after the 6th byte; buffer_addr=0x1234, buffer_data=0xDEADBEEF, buffer_count=1; pulse buffer_read_enable -> buffer_empty=1, count=0.
2. Fill to full: 16 packets with data 0..15, no pops -> buffer_count=16; in_ready drops when byte_cnt=5; 17th packet's bytes 0-4 are accepted and the 6th is stalled; one pop -> in_ready=1, the 17th packet is pushed, and the head now reads data=1.
3. Simultaneous push/pop at count=1: last byte of packet B and pop of packet A on the same edge -> count stays 1, buffer_empty stays 0, head=B.
4. Pop while empty: buffer_read_enable=1 for 5 cycles at reset state -> count stays 0, buffer_empty stays 1; a following packet reads back correctly.
5. Wrap-around: push and pop 40 packets with data=i, interleaved -> every head matches in order across the pointer wrap.
6. Reset mid-packet: 3 bytes sent, then reset asserted for 1 cycle, then a full packet 01 00 04 03 02 01 -> addr=0x0001, data=0x01020304. With HOST_PACKET_BUFFER_TIMEOUT_EN and TIMEOUT_CYCLES=8: 2 bytes then 8 idle cycles -> timeout_pulse for one cycle and count=0; the next 6 bytes form a correct packet.

Source files
------------

// File: rtl/host_packet_buffer.sv
// Host byte stream to packet FIFO: assembles little-endian {address, data} packets
// and presents them first-word-fall-through. Define HOST_PACKET_BUFFER_TIMEOUT_EN to discard stale partial packets.
module host_packet_buffer #(
  parameter int BUFFER_LENGTH  = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int FIFO_DEPTH     = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          buffer_empty,
  output logic [BUFFER_LENGTH-1:0]      buffer_addr,
  output logic [DATA_WIDTH-1:0]         buffer_data,
  input  logic                          buffer_read_enable,
  output logic [$clog2(FIFO_DEPTH):0]   buffer_count,
  output logic                          timeout_pulse
);

  localparam int ADDR_BYTES = (BUFFER_LENGTH + 7) / 8;
  localparam int DATA_BYTES = DATA_WIDTH / 8;
  localparam int PKT_BYTES  = ADDR_BYTES + DATA_BYTES;
  localparam int PKT_BITS   = PKT_BYTES * 8;
  localparam int CNT_W      = $clog2(PKT_BYTES);
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int ENTRY_W    = BUFFER_LENGTH + DATA_WIDTH;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(PKT_BYTES - 1);

  logic [CNT_W-1:0]          byte_cnt;
  logic [PKT_BITS-1:0]       pkt_reg;
  logic [PKT_BITS-1:0]       pkt_next;
  logic [ENTRY_W-1:0]        entry_next;
  logic [ENTRY_W-1:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]          wr_ptr;
  logic [PTR_W-1:0]          rd_ptr;
  logic [$clog2(FIFO_DEPTH):0] count_next;
  logic                      full;
  logic                      accept;
  logic                      last_byte;
  logic                      push;
  logic                      pop;
  logic                      expire;

  // in_ready looks only at registered state, so the host never sees the pop path.
  assign last_byte = (byte_cnt == LAST_BYTE);
  assign in_ready  = ~last_byte | ~full;
  assign accept    = in_valid & in_ready;
  assign push      = accept & last_byte;
  assign pop       = buffer_read_enable & ~buffer_empty;

  always_comb begin
    pkt_next = pkt_reg;
    for (int i = 0; i < PKT_BYTES; i++) begin
      if (byte_cnt == CNT_W'(i)) pkt_next[i*8 +: 8] = in_data;
    end
  end

  assign entry_next = {pkt_next[BUFFER_LENGTH-1:0], pkt_next[ADDR_BYTES*8 +: DATA_WIDTH]};

  always_comb begin
    count_next = buffer_count;
    if (push && !pop)      count_next = buffer_count + 1'b1;
    else if (!push && pop) count_next = buffer_count - 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_cnt     <= '0;
      pkt_reg      <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      buffer_count <= '0;
      full         <= 1'b0;
      buffer_empty <= 1'b1;
    end else begin
      if (accept) begin
        pkt_reg  <= pkt_next;
        byte_cnt <= last_byte ? '0 : byte_cnt + 1'b1;
      end else if (expire) begin
        byte_cnt <= '0;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      buffer_count <= count_next;
      full         <= (count_next == ($clog2(FIFO_DEPTH)+1)'(FIFO_DEPTH));
      buffer_empty <= (count_next == '0);
    end
  end

  // Storage is deliberately left out of reset; the pointers make stale entries invisible.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= entry_next;
  end

  assign {buffer_addr, buffer_data} = mem[rd_ptr];

`ifdef HOST_PACKET_BUFFER_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [IDLE_W-1:0] idle_cnt;

  // A byte arriving in the expiry cycle wins, so expiry requires no acceptance.
  assign expire = (byte_cnt != '0) && !accept && (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_cnt      <= '0;
      timeout_pulse <= 1'b0;
    end else begin
      timeout_pulse <= expire;
      if (accept || byte_cnt == '0 || expire) idle_cnt <= '0;
      else                                    idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  assign expire        = 1'b0;
  assign timeout_pulse = 1'b0;
`endif

endmodule
